// File: rtl/irq_trap_sequencer_if.sv
// Trap request handshake between the interrupt sequencer and the CSR trap unit.
interface irq_trap_sequencer_if;
  logic       irq_req_o;
  logic [3:0] irq_code_o;
  logic       irq_flush_lsu_o;
  logic       irq_ack_in;

  // Sequencer side: raises the request and cause, consumes the commit ack.
  modport master (
    output irq_req_o,
    output irq_code_o,
    output irq_flush_lsu_o,
    input  irq_ack_in
  );

  // CSR trap unit side.
  modport slave (
    input  irq_req_o,
    input  irq_code_o,
    input  irq_flush_lsu_o,
    output irq_ack_in
  );
endinterface

// File: rtl/irq_trap_sequencer.sv
// Machine-mode interrupt front-end: synchronises raw interrupt lines, masks
// them with mie / global enable, selects the highest-priority cause and runs
// a held request/ack handshake into the CSR trap logic. Also sequences WFI
// sleep/wake and a short post-trap holdoff.
module irq_trap_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int ACK_TIMEOUT    = 15,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  irq_trap_sequencer_if.master        trap,
  input  logic [1:0]                  ext_irq_in,
  input  logic                        timer_irq_in,
  input  logic                        soft_irq_in,
  input  logic                        uart_irq_in,
  input  logic [31:0]                 mie_in,
  input  logic                        mstatus_mie_in,
  input  logic [1:0]                  priv_mode_in,
  input  logic                        exc_req_in,
  input  logic                        pipe_stall_in,
  input  logic                        wfi_req_in,
  output logic [31:0]                 mip_o,
  output logic                        wfi_stall_o,
  output logic                        wfi_wake_o,
  output logic                        timeout_o
);

  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  localparam logic [3:0] CODE_MEI = 4'd11;
  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_SEI = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_WFI  = 2'd3
  } state_t;

  // Fixed priority MEI > MSI > MTI > SEI; 0 when nothing is enabled.
  function automatic logic [3:0] pick_code(input logic [31:0] en);
    logic [3:0] code;
    if (en[11]) begin
      code = CODE_MEI;
    end else if (en[3]) begin
      code = CODE_MSI;
    end else if (en[7]) begin
      code = CODE_MTI;
    end else if (en[9]) begin
      code = CODE_SEI;
    end else begin
      code = 4'd0;
    end
    return code;
  endfunction

  // Raw lines in a fixed lane order: {uart, soft, timer, sei, mei}.
  logic [4:0]  raw_s;
  logic [4:0]  sync_r [SYNC_STAGES-1];
  logic [4:0]  sync_last_s;
  // Final synchroniser stage, already merged: {mei|uart, sei, mti, msi}.
  logic [3:0]  mip_r;
  logic [31:0] mip_s;
  logic [31:0] enabled_s;
  logic        gen_s;
  logic        fire_s;

  state_t            state_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              req_r;
  logic              flush_r;
  logic [3:0]        code_r;
  logic              stall_r;
  logic              wake_r;
  logic              timeout_r;

  assign raw_s       = {uart_irq_in, soft_irq_in, timer_irq_in, ext_irq_in[1], ext_irq_in[0]};
  assign sync_last_s = sync_r[SYNC_STAGES-2];

  // Synchroniser chain; the last flop stage also performs the UART-into-MEI merge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES - 1; i++) begin
        sync_r[i] <= 5'd0;
      end
      mip_r <= 4'd0;
    end else begin
      sync_r[0] <= raw_s;
      for (int i = SYNC_STAGES - 2; i > 0; i--) begin
        sync_r[i] <= sync_r[i-1];
      end
      mip_r <= {sync_last_s[0] | sync_last_s[4], sync_last_s[1], sync_last_s[2], sync_last_s[3]};
    end
  end

  assign mip_s     = {20'd0, mip_r[3], 1'b0, mip_r[2], 1'b0, mip_r[1], 3'd0, mip_r[0], 3'd0};
  assign enabled_s = mip_s & mie_in;
  assign gen_s     = (priv_mode_in != 2'b11) | mstatus_mie_in;
  assign fire_s    = (|enabled_s) & gen_s & ~exc_req_in & ~pipe_stall_in;

  // Trap sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      tmo_cnt_r  <= '0;
      hold_cnt_r <= '0;
      req_r      <= 1'b0;
      flush_r    <= 1'b0;
      code_r     <= 4'd0;
      stall_r    <= 1'b0;
      wake_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      wake_r    <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (wfi_req_in) begin
            state_r <= ST_WFI;
            stall_r <= 1'b1;
          end else if (fire_s) begin
            state_r   <= ST_REQ;
            req_r     <= 1'b1;
            flush_r   <= 1'b1;
            code_r    <= pick_code(enabled_s);
            tmo_cnt_r <= '0;
          end
        end
        ST_REQ: begin
          // Ack takes precedence over an expiring timeout on the same cycle.
          if (trap.irq_ack_in) begin
            state_r    <= ST_HOLD;
            req_r      <= 1'b0;
            flush_r    <= 1'b0;
            code_r     <= 4'd0;
            hold_cnt_r <= '0;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            flush_r   <= 1'b0;
            code_r    <= 4'd0;
            timeout_r <= 1'b1;
          end else if (tmo_cnt_r < TMO_LAST) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_HOLD: begin
          // Gives a trap-entry clear of mstatus.MIE time to reach gen.
          if (hold_cnt_r == HOLD_LAST) begin
            state_r <= ST_IDLE;
          end else if (hold_cnt_r < HOLD_LAST) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_WFI: begin
          // Wake ignores the global enable; IDLE decides whether to trap.
          if (|enabled_s) begin
            state_r <= ST_IDLE;
            stall_r <= 1'b0;
            wake_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          flush_r <= 1'b0;
          code_r  <= 4'd0;
          stall_r <= 1'b0;
        end
      endcase
    end
  end

  assign trap.irq_req_o       = req_r;
  assign trap.irq_code_o      = code_r;
  assign trap.irq_flush_lsu_o = flush_r;
  assign mip_o                = mip_s;
  assign wfi_stall_o          = stall_r;
  assign wfi_wake_o           = wake_r;
  assign timeout_o            = timeout_r;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Directed bench for irq_trap_sequencer. Stimulus pushes cycle-exact expected
// events (request rise with cause, timeout pulse, wake pulse) into a queue; a
// monitor on the falling edge pops and compares whenever the DUT shows one.
module tb_irq_trap_sequencer;

  localparam logic [1:0] K_REQ  = 2'd0;
  localparam logic [1:0] K_TMO  = 2'd1;
  localparam logic [1:0] K_WAKE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  code;
    logic [31:0] cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ext_irq_in = 2'd0;
  logic        timer_irq_in = 1'b0;
  logic        soft_irq_in = 1'b0;
  logic        uart_irq_in = 1'b0;
  logic [31:0] mie_in = 32'd0;
  logic        mstatus_mie_in = 1'b0;
  logic [1:0]  priv_mode_in = 2'b11;
  logic        exc_req_in = 1'b0;
  logic        pipe_stall_in = 1'b0;
  logic        wfi_req_in = 1'b0;
  logic [31:0] mip_o;
  logic        wfi_stall_o;
  logic        wfi_wake_o;
  logic        timeout_o;

  irq_trap_sequencer_if trap_if ();

  irq_trap_sequencer #(
    .SYNC_STAGES(2), .ACK_TIMEOUT(15), .HOLDOFF_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .trap(trap_if),
    .ext_irq_in(ext_irq_in), .timer_irq_in(timer_irq_in),
    .soft_irq_in(soft_irq_in), .uart_irq_in(uart_irq_in),
    .mie_in(mie_in), .mstatus_mie_in(mstatus_mie_in),
    .priv_mode_in(priv_mode_in), .exc_req_in(exc_req_in),
    .pipe_stall_in(pipe_stall_in), .wfi_req_in(wfi_req_in),
    .mip_o(mip_o), .wfi_stall_o(wfi_stall_o),
    .wfi_wake_o(wfi_wake_o), .timeout_o(timeout_o)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] b;
  logic        prev_req = 1'b0;
  sb_t         sb_q[$];

  always #5 clk = ~clk;

  // Rising-edge count used to time-stamp expected and observed events.
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input logic [1:0] k, input logic [3:0] c, input logic [31:0] at);
    sb_t e;
    e.kind = k;
    e.code = c;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic check_event(input logic [1:0] k, input logic [3:0] c);
    sb_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_unexpected: got kind=%0d code=%0d at cyc %0d, required no event", k, c, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind !== k || e.code !== c || e.cyc !== cyc) begin
        miscompares++;
        $display("FAIL sb_event: got kind=%0d code=%0d cyc=%0d, required kind=%0d code=%0d cyc=%0d",
                 k, c, cyc, e.kind, e.code, e.cyc);
      end
    end
  endtask

  // Advance on falling edges until the rising-edge count reaches c.
  task automatic go(input logic [31:0] c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every observable output event against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (trap_if.irq_req_o && !prev_req) check_event(K_REQ, trap_if.irq_code_o);
      if (timeout_o) check_event(K_TMO, 4'd0);
      if (wfi_wake_o) check_event(K_WAKE, 4'd0);
    end
    prev_req <= trap_if.irq_req_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    trap_if.irq_ack_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, trap_if.irq_req_o}, 32'd0);
    chk("rst_code", {28'd0, trap_if.irq_code_o}, 32'd0);
    chk("rst_flush", {31'd0, trap_if.irq_flush_lsu_o}, 32'd0);
    chk("rst_mip", mip_o, 32'd0);
    chk("rst_outs", {29'd0, wfi_stall_o, wfi_wake_o, timeout_o}, 32'd0);
    rst = 1'b1;
    go(cyc + 32'd2);

    // Timer alone: request 3 cycles after the pin, then a 2-cycle holdoff.
    b = cyc;
    timer_irq_in = 1'b1; mie_in = 32'h80; mstatus_mie_in = 1'b1; priv_mode_in = 2'b11;
    sb_push(K_REQ, 4'd7, b + 32'd3);
    sb_push(K_REQ, 4'd7, b + 32'd7);
    go(b + 32'd2);
    chk("t1_latency_no_req", {31'd0, trap_if.irq_req_o}, 32'd0);
    chk("t1_mip", mip_o, 32'h80);
    go(b + 32'd3);
    chk("t1_flush", {31'd0, trap_if.irq_flush_lsu_o}, 32'd1);
    trap_if.irq_ack_in = 1'b1;
    go(b + 32'd4);
    trap_if.irq_ack_in = 1'b0;
    chk("t1_req_drop", {31'd0, trap_if.irq_req_o}, 32'd0);
    go(b + 32'd6);
    chk("t1_hold_low", {31'd0, trap_if.irq_req_o}, 32'd0);
    go(b + 32'd7);
    trap_if.irq_ack_in = 1'b1; timer_irq_in = 1'b0;
    go(b + 32'd8);
    trap_if.irq_ack_in = 1'b0;
    go(b + 32'd12);
    chk("t1_idle", {31'd0, trap_if.irq_req_o}, 32'd0);

    // Priority: MEI, MEI again after holdoff, then MSI once ext drops.
    b = cyc;
    timer_irq_in = 1'b1; soft_irq_in = 1'b1; ext_irq_in = 2'b01; mie_in = 32'h888;
    sb_push(K_REQ, 4'd11, b + 32'd3);
    sb_push(K_REQ, 4'd11, b + 32'd7);
    sb_push(K_REQ, 4'd3, b + 32'd11);
    go(b + 32'd3);  trap_if.irq_ack_in = 1'b1;
    go(b + 32'd4);  trap_if.irq_ack_in = 1'b0;
    go(b + 32'd7);  trap_if.irq_ack_in = 1'b1; ext_irq_in = 2'b00;
    go(b + 32'd8);  trap_if.irq_ack_in = 1'b0;
    go(b + 32'd11); trap_if.irq_ack_in = 1'b1; soft_irq_in = 1'b0; timer_irq_in = 1'b0;
    go(b + 32'd12); trap_if.irq_ack_in = 1'b0;
    go(b + 32'd16);

    // Blockers: exception, stall, global disable in M; then U-mode fires.
    b = cyc;
    timer_irq_in = 1'b1; mie_in = 32'h80; exc_req_in = 1'b1;
    go(b + 32'd6);
    chk("blk_exc", {31'd0, trap_if.irq_req_o}, 32'd0);
    exc_req_in = 1'b0; pipe_stall_in = 1'b1;
    go(b + 32'd10);
    chk("blk_stall", {31'd0, trap_if.irq_req_o}, 32'd0);
    pipe_stall_in = 1'b0; mstatus_mie_in = 1'b0;
    go(b + 32'd14);
    chk("blk_gen", {31'd0, trap_if.irq_req_o}, 32'd0);
    sb_push(K_REQ, 4'd7, b + 32'd15);
    priv_mode_in = 2'b00;
    go(b + 32'd15); trap_if.irq_ack_in = 1'b1; timer_irq_in = 1'b0; priv_mode_in = 2'b11;
    go(b + 32'd16); trap_if.irq_ack_in = 1'b0; mstatus_mie_in = 1'b1;
    go(b + 32'd20);

    // Timeout: 15 request cycles without ack.
    b = cyc;
    timer_irq_in = 1'b1;
    sb_push(K_REQ, 4'd7, b + 32'd3);
    sb_push(K_TMO, 4'd0, b + 32'd18);
    go(b + 32'd5);  timer_irq_in = 1'b0;
    go(b + 32'd17);
    chk("tmo_req_held", {31'd0, trap_if.irq_req_o}, 32'd1);
    chk("tmo_not_yet", {31'd0, timeout_o}, 32'd0);
    go(b + 32'd18);
    chk("tmo_req_drop", {31'd0, trap_if.irq_req_o}, 32'd0);
    go(b + 32'd22);

    // Ack on the 15th request cycle wins over the timeout.
    b = cyc;
    timer_irq_in = 1'b1;
    sb_push(K_REQ, 4'd7, b + 32'd3);
    go(b + 32'd5);  timer_irq_in = 1'b0;
    go(b + 32'd17); trap_if.irq_ack_in = 1'b1;
    go(b + 32'd18); trap_if.irq_ack_in = 1'b0;
    chk("ack_wins_tmo", {31'd0, timeout_o}, 32'd0);
    chk("ack_wins_req", {31'd0, trap_if.irq_req_o}, 32'd0);
    go(b + 32'd22);

    // WFI with global enable off: wake pulse only, no request.
    b = cyc;
    wfi_req_in = 1'b1; mie_in = 32'h800; mstatus_mie_in = 1'b0;
    go(b + 32'd1);
    wfi_req_in = 1'b0;
    chk("wfi_stall", {31'd0, wfi_stall_o}, 32'd1);
    go(b + 32'd4);
    chk("wfi_stall_held", {31'd0, wfi_stall_o}, 32'd1);
    uart_irq_in = 1'b1;
    sb_push(K_WAKE, 4'd0, b + 32'd7);
    go(b + 32'd7);
    chk("wfi_stall_drop", {31'd0, wfi_stall_o}, 32'd0);
    go(b + 32'd12);
    chk("wfi_no_req", {31'd0, trap_if.irq_req_o}, 32'd0);
    chk("wfi_uart_mip", mip_o, 32'h800);
    uart_irq_in = 1'b0;
    go(b + 32'd16);

    // WFI with global enable on: wake then trap on the following edge.
    b = cyc;
    wfi_req_in = 1'b1; mstatus_mie_in = 1'b1;
    go(b + 32'd1);  wfi_req_in = 1'b0;
    go(b + 32'd4);  ext_irq_in = 2'b01;
    sb_push(K_WAKE, 4'd0, b + 32'd7);
    sb_push(K_REQ, 4'd11, b + 32'd8);
    go(b + 32'd8);  trap_if.irq_ack_in = 1'b1; ext_irq_in = 2'b00;
    go(b + 32'd9);  trap_if.irq_ack_in = 1'b0;
    go(b + 32'd14);

    // Asynchronous reset in the middle of a request.
    b = cyc;
    mie_in = 32'h80; timer_irq_in = 1'b1;
    sb_push(K_REQ, 4'd7, b + 32'd3);
    go(b + 32'd4);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, trap_if.irq_req_o}, 32'd0);
    chk("rst_mid_code", {28'd0, trap_if.irq_code_o}, 32'd0);
    chk("rst_mid_flush", {31'd0, trap_if.irq_flush_lsu_o}, 32'd0);
    @(negedge clk);
    timer_irq_in = 1'b0; rst = 1'b1;

    // Asynchronous reset during WFI sleep.
    b = cyc;
    wfi_req_in = 1'b1;
    go(b + 32'd1);
    wfi_req_in = 1'b0;
    chk("wfi2_stall", {31'd0, wfi_stall_o}, 32'd1);
    go(b + 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_wfi", {31'd0, wfi_stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    go(cyc + 32'd5);

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d expected events never seen, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
